adder_tree_seq: RTL and testbench

Sequencer that time-multiplexes one `adderTree_1D_p4` instance (4-ary pipelined adder tree, CHUNK_SIZE inputs) across a long input vector. It splits the vector into NUM_CHUNKS chunks, issues one chunk per cycle into the tree, and accumulates the returning partial sums into a single result. A valid/ready handshake sits on both sides. It is used in the batchnorm/dense reduction path wherever the vector length exceeds one tree's width.

---
 rtl/adder_tree_pkg.sv | 43 ++++
 rtl/adderTree_1D_p4.sv | 78 +++++++
 rtl/adder_tree_seq.sv | 186 ++++++++++++++++++
 tb/tb_adder_tree_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
//------------------------------------------------------------------------------
// adder_tree_pkg
//
// Shared definitions for the adder-tree reduction path.
//
// Contents:
//   seq_state_t   - sequencer FSM encoding (IDLE, ISSUE, DRAIN, DONE)
//   tree_latency  - cycles from a tree input being presented to its sum being
//                   visible on the tree output (input register plus one
//                   register per 4-ary reduction level)
//   sat_signed    - clips a signed 64-bit value into a signed 'width'-bit range
//------------------------------------------------------------------------------
package adder_tree_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // ceil(log4(n)) reduction levels, computed as ceil(ceil(log2(n)) / 2),
   // plus the input register stage.
   function automatic int tree_latency(input int chunk_size);
      return (($clog2(chunk_size) + 1) / 2) + 1;
   endfunction

   // Saturate a signed value to the range of a signed 'width'-bit number.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int                 width);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (value > max_v) begin
         return max_v;
      end else if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

endpackage : adder_tree_pkg

// File: rtl/adderTree_1D_p4.sv
//------------------------------------------------------------------------------
// adderTree_1D_p4
//
// Pipelined 4-ary adder tree. Sums INPUT_SIZE elements of WIDTH bits. Every
// add wraps at WIDTH bits; callers are responsible for keeping the sum inside
// range. There is no reset: the tree only carries data, and whoever consumes
// its output tracks validity separately.
//
// Latency: tree_latency(INPUT_SIZE) cycles. One register stage captures the
// inputs, then each 4-ary reduction level is registered.
//
// Ports:
//   clk       in   clock
//   in_data   in   [INPUT_SIZE-1:0][WIDTH-1:0]  operands, element i = in_data[i]
//   out_data  out  [WIDTH-1:0]                  registered sum
//------------------------------------------------------------------------------
module adderTree_1D_p4
   import adder_tree_pkg::*;
#(
   parameter int WIDTH      = 17,
   parameter int INPUT_SIZE = 16
) (
   input  logic                             clk,
   input  logic [INPUT_SIZE-1:0][WIDTH-1:0] in_data,
   output logic [WIDTH-1:0]                 out_data
);

   localparam int LEVELS = tree_latency(INPUT_SIZE) - 1;
   // Inputs are zero-padded up to the next power of four so every level
   // reduces groups of exactly four.
   localparam int PAD    = 4 ** LEVELS;

   // Offset of level l within the flattened node array. Level 0 holds the
   // PAD padded inputs, level l holds PAD/4^l partial sums; the root is last.
   function automatic int lvl_off(input int l);
      int o;
      o = 0;
      for (int i = 0; i < l; i++) begin
         o += PAD >> (2 * i);
      end
      return o;
   endfunction

   localparam int NODES = lvl_off(LEVELS + 1);

   wire  [NODES-1:0][WIDTH-1:0]      node;
   logic [INPUT_SIZE-1:0][WIDTH-1:0] in_q;

   always_ff @(posedge clk) begin
      in_q <= in_data;
   end

   assign node[INPUT_SIZE-1:0] = in_q;

   if (PAD > INPUT_SIZE) begin : g_pad
      assign node[PAD-1:INPUT_SIZE] = '0;
   end

   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int CNT = PAD >> (2 * l);
      localparam int SRC = lvl_off(l - 1);
      localparam int DST = lvl_off(l);

      logic [CNT-1:0][WIDTH-1:0] sum_q;

      always_ff @(posedge clk) begin
         for (int j = 0; j < CNT; j++) begin
            sum_q[j] <= node[SRC + 4*j]     + node[SRC + 4*j + 1]
                      + node[SRC + 4*j + 2] + node[SRC + 4*j + 3];
         end
      end

      assign node[DST+CNT-1:DST] = sum_q;
   end

   assign out_data = node[NODES-1];

endmodule : adderTree_1D_p4

// File: rtl/adder_tree_seq.sv
//------------------------------------------------------------------------------
// adder_tree_seq
//
// Reduces a CHUNK_SIZE*NUM_CHUNKS element vector to a single sum by feeding
// one chunk per cycle through a shared adderTree_1D_p4 and accumulating the
// partial sums as they come out of the tree.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The block raises in_ready only in IDLE and
// accepts one vector at a time; out_valid stays high with out_data/out_sat
// held stable until out_ready is seen. Valid is never withdrawn by this block
// before its transfer completes.
//
// Build option:
//   ADDER_TREE_SEQ_SAT_EN  defined   -> out_data is the accumulator saturated to
//                                       the signed WIDTH range, out_sat flags it
//                          undefined -> out_data is the accumulator's low WIDTH
//                                       bits (wraps), out_sat is 0
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous reset, active low
//   in_valid   in   input vector valid
//   in_ready   out  block can accept a vector (IDLE)
//   in_data    in   [CHUNK_SIZE*NUM_CHUNKS-1:0][WIDTH-1:0] two's-complement
//                   elements; element e belongs to chunk e/CHUNK_SIZE
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts the result
//   out_data   out  signed vector sum
//   out_sat    out  result was clipped
//   dbg_state  out  current FSM state (seq_state_t encoding)
//------------------------------------------------------------------------------
module adder_tree_seq
   import adder_tree_pkg::*;
#(
   parameter int WIDTH      = 17,
   parameter int CHUNK_SIZE = 16,
   parameter int NUM_CHUNKS = 4
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [CHUNK_SIZE*NUM_CHUNKS-1:0][WIDTH-1:0] in_data,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic signed [WIDTH-1:0]                     out_data,
   output logic                                        out_sat,
   output logic [1:0]                                  dbg_state
);

   localparam int TOTAL    = CHUNK_SIZE * NUM_CHUNKS;
   localparam int TREE_LAT = tree_latency(CHUNK_SIZE);
   // Wide enough that NUM_CHUNKS full-scale partials never wrap.
   localparam int ACC_W    = WIDTH + $clog2(NUM_CHUNKS) + 1;
   localparam int IDX_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int CNT_W    = $clog2(NUM_CHUNKS + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
   localparam logic [CNT_W-1:0] ALL_RET  = CNT_W'(NUM_CHUNKS);

   seq_state_t                       state;
   logic [TOTAL-1:0][WIDTH-1:0]      vec_q;
   logic [IDX_W-1:0]                 issue_idx;
   logic [CNT_W-1:0]                 ret_cnt;
   logic [CNT_W-1:0]                 ret_next;
   logic [TREE_LAT-1:0]              vld_pipe;
   logic                             tail;
   logic signed [ACC_W-1:0]          acc;
   logic signed [ACC_W-1:0]          partial;
   logic [CHUNK_SIZE-1:0][WIDTH-1:0] chunk;
   logic [WIDTH-1:0]                 tree_sum;
   logic                             capture;

   assign capture  = (state == IDLE) && in_valid;
   assign tail     = vld_pipe[TREE_LAT-1];
   assign partial  = ACC_W'($signed(tree_sum));
   assign ret_next = ret_cnt + CNT_W'(tail);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign dbg_state = state;

   //---------------------------------------------------------------------------
   // Chunk select on the captured vector. Outside ISSUE the tree still sees a
   // chunk, but the valid pipe is not fed, so that result is never used.
   //---------------------------------------------------------------------------
   always_comb begin
      chunk = '0;
      for (int c = 0; c < NUM_CHUNKS; c++) begin
         if (issue_idx == IDX_W'(c)) begin
            chunk = vec_q[c*CHUNK_SIZE +: CHUNK_SIZE];
         end
      end
   end

   adderTree_1D_p4 #(
      .WIDTH      (WIDTH),
      .INPUT_SIZE (CHUNK_SIZE)
   ) u_tree (
      .clk      (clk),
      .in_data  (chunk),
      .out_data (tree_sum)
   );

   // Captured vector: plain data, only loaded on an input transfer.
   always_ff @(posedge clk) begin
      if (capture) begin
         vec_q <= in_data;
      end
   end

   //---------------------------------------------------------------------------
   // Sequencer, valid pipe and accumulator.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         issue_idx <= '0;
         ret_cnt   <= '0;
         vld_pipe  <= '0;
         acc       <= '0;
      end else begin
         // A bit enters the pipe alongside each issued chunk and reaches the
         // tail exactly when that chunk's sum is on tree_sum.
         vld_pipe <= (vld_pipe << 1) | TREE_LAT'(state == ISSUE);

         if (tail) begin
            acc     <= acc + partial;
            ret_cnt <= ret_next;
         end

         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc       <= '0;
                  ret_cnt   <= '0;
                  issue_idx <= '0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (issue_idx == LAST_IDX) begin
                  state <= DRAIN;
               end else begin
                  issue_idx <= issue_idx + IDX_W'(1);
               end
            end
            DRAIN: begin
               // Look at the count including this cycle's return so DONE is
               // entered on the same edge the last partial is accumulated.
               if (ret_next == ALL_RET) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Result formatting, purely from the accumulator, so it holds through DONE.
   //---------------------------------------------------------------------------
`ifdef ADDER_TREE_SEQ_SAT_EN
   logic signed [63:0] acc_ext;
   logic signed [63:0] acc_sat;

   always_comb begin
      acc_ext  = 64'(acc);
      acc_sat  = sat_signed(acc_ext, WIDTH);
      out_data = acc_sat[WIDTH-1:0];
      out_sat  = (acc_sat != acc_ext);
   end
`else
   always_comb begin
      out_data = acc[WIDTH-1:0];
      out_sat  = 1'b0;
   end
`endif

endmodule : adder_tree_seq

// File: tb/tb_adder_tree_seq.sv
//------------------------------------------------------------------------------
// tb_adder_tree_seq
//
// Directed bench for adder_tree_seq: a default-sized instance (4 chunks of 16)
// and a single-chunk instance. Expected sums are hand computed.
//------------------------------------------------------------------------------
module tb_adder_tree_seq;

   localparam int W   = 17;
   localparam int CS  = 16;
   localparam int NC  = 4;
   localparam int TOT = CS * NC;

`ifdef ADDER_TREE_SEQ_SAT_EN
   localparam int   BIG_SUM = 65535;
   localparam logic BIG_SAT = 1'b1;
`else
   localparam int   BIG_SUM = -6144;
   localparam logic BIG_SAT = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // Clock / reset
   //---------------------------------------------------------------------------
   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   // Default instance
   logic                    in_valid;
   logic                    in_ready;
   logic [TOT-1:0][W-1:0]   in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [W-1:0]     out_data;
   logic                    out_sat;
   logic [1:0]              dbg_state;

   // Single-chunk instance
   logic                    in_valid1;
   logic                    in_ready1;
   logic [CS-1:0][W-1:0]    in_data1;
   logic                    out_valid1;
   logic                    out_ready1;
   logic signed [W-1:0]     out_data1;
   logic                    out_sat1;
   logic [1:0]              dbg_state1;

   adder_tree_seq #(.WIDTH(W), .CHUNK_SIZE(CS), .NUM_CHUNKS(NC)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .dbg_state (dbg_state)
   );

   adder_tree_seq #(.WIDTH(W), .CHUNK_SIZE(CS), .NUM_CHUNKS(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .in_data   (in_data1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .out_data  (out_data1),
      .out_sat   (out_sat1),
      .dbg_state (dbg_state1)
   );

   //---------------------------------------------------------------------------
   // Scoreboard
   //---------------------------------------------------------------------------
   int              n_cmp = 0;
   int              n_bad = 0;
   logic [W-1:0]    exp_q[$];
   logic [TOT-1:0][W-1:0] vec;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   //---------------------------------------------------------------------------
   // Driver tasks (all activity on the falling edge)
   //---------------------------------------------------------------------------
   task automatic scramble_in();
      for (int e = 0; e < TOT; e++) begin
         in_data[e] = W'($urandom);
      end
   endtask

   // Present vec and complete one input transfer; returns on the falling edge
   // right after the accepting rising edge.
   task automatic send_vec();
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("send_in_ready", in_ready, 1);
      in_data  = vec;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      scramble_in();
   endtask

   // Wait for the result, compare against the head of exp_q, optionally hold
   // out_ready low for 'hold' cycles while poking in_valid, then accept it.
   task automatic wait_result(input string tag, input logic exp_sat,
                              input int exp_lat, input int hold);
      int           lat;
      logic [W-1:0] exp_sum;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      exp_sum = '0;
      if (exp_q.size() > 0) begin
         exp_sum = exp_q.pop_front();
      end
      chk({tag, "_sum"}, out_data, $signed(exp_sum));
      chk({tag, "_sat"}, out_sat, exp_sat);
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         scramble_in();
         @(negedge clk);
         chk({tag, "_hold_sum"}, out_data, $signed(exp_sum));
         chk({tag, "_hold_in_ready"}, in_ready, 0);
         chk({tag, "_hold_out_valid"}, out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_in_ready_after"}, in_ready, 1);
      chk({tag, "_out_valid_after"}, out_valid, 0);
   endtask

   //---------------------------------------------------------------------------
   // Watchdog
   //---------------------------------------------------------------------------
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected summary");
      $fatal(1, "watchdog expired");
   end

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   initial begin
      int t;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_data    = '0;
      in_valid1  = 1'b0;
      out_ready1 = 1'b0;
      in_data1   = '0;
      vec        = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_in_ready1", in_ready1, 1);
      reset = 1'b1;
      @(negedge clk);

      // All ones -> 64
      for (int e = 0; e < TOT; e++) vec[e] = W'(1);
      send_vec();
      exp_q.push_back(W'(64));
      wait_result("ones", 1'b0, 7, 0);

      // Ramp 1..64 -> 2080, with a held-off consumer
      for (int e = 0; e < TOT; e++) vec[e] = W'(e + 1);
      send_vec();
      exp_q.push_back(W'(2080));
      wait_result("ramp", 1'b0, 7, 5);

      // All 4000 -> 256000, clipped or wrapped depending on the build
      for (int e = 0; e < TOT; e++) vec[e] = W'(4000);
      send_vec();
      exp_q.push_back(W'(BIG_SUM));
      wait_result("big", BIG_SAT, 7, 0);

      // Abort a vector during DRAIN with a one-cycle reset
      for (int e = 0; e < TOT; e++) vec[e] = W'(7);
      send_vec();
      t = 0;
      while (dbg_state != 2'd2 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("drain_reached", dbg_state, 2);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_data", out_data, 0);
      chk("abort_state", dbg_state, 0);
      reset = 1'b1;
      @(negedge clk);

      for (int e = 0; e < TOT; e++) vec[e] = W'(2);
      send_vec();
      exp_q.push_back(W'(128));
      wait_result("post_reset", 1'b0, 7, 0);

      // Single chunk: 16 x -3 -> -48 after 4 cycles
      for (int e = 0; e < CS; e++) in_data1[e] = W'(-3);
      chk("one_in_ready", in_ready1, 1);
      in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      t = 0;
      while (!out_valid1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("one_lat", t, 4);
      chk("one_sum", out_data1, -48);
      chk("one_sat", out_sat1, 0);
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      chk("one_in_ready_after", in_ready1, 1);
      chk("one_out_valid_after", out_valid1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_adder_tree_seq
